// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic units.
package serial_subtractor_pkg;

    // Controller states; encodings are kept stable for reuse by a serial adder.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Bit-counter width: enough to count 0..w-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        int unsigned r;
        r = (w > 1) ? $unsigned($clog2(w)) : 1;
        return r;
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: DIFF = A - B - BIN, BOUT = borrow out.
module full_subtractor (
    input  logic A,
    input  logic B,
    input  logic BIN,
    output logic DIFF,
    output logic BOUT
);

    // Pure combinational difference/borrow equations.
    always_comb begin
        DIFF = A ^ B ^ BIN;
        BOUT = (~A & B) | (~(A ^ B) & BIN);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: DIFF = A - B - BIN, one bit per clock, LSB first,
// with a START/DONE handshake around a single reused full-subtractor cell.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] DIFF,
    output logic             BORROW
);

    localparam int unsigned    CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_e           state_q,  state_d;
    logic [CW-1:0]    count_q,  count_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic             br_q,     br_d;
    logic [WIDTH-1:0] res_q,    res_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic             borrow_q, borrow_d;

    logic             cell_d;
    logic             cell_bo;
    logic [WIDTH-1:0] res_shift;

    full_subtractor u_cell (
        .A    (a_q[0]),
        .B    (b_q[0]),
        .BIN  (br_q),
        .DIFF (cell_d),
        .BOUT (cell_bo)
    );

    // Result register with the current difference bit entering at the MSB.
    always_comb begin
        res_shift            = res_q >> 1;
        res_shift[WIDTH-1]   = cell_d;
    end

    // Next-state and datapath control for the IDLE -> SHIFT -> DONE sequence.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        a_d      = a_q;
        b_d      = b_q;
        br_d     = br_q;
        res_d    = res_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    a_d     = A;
                    b_d     = B;
                    br_d    = BIN;
                    count_d = '0;
                    res_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                res_d   = res_shift;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                br_d    = cell_bo;
                count_d = count_q + 1'b1;
                if (count_q == LAST) begin
                    // Output registers load the final result/borrow on the same
                    // edge, so they are valid in the DONE cycle and hold afterwards.
                    diff_d   = res_shift;
                    borrow_d = cell_bo;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            br_q     <= 1'b0;
            res_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            a_q      <= a_d;
            b_q      <= b_d;
            br_q     <= br_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    // Status and result outputs.
    always_comb begin
        BUSY   = (state_q == ST_SHIFT);
        DONE   = (state_q == ST_DONE);
        DIFF   = diff_q;
        BORROW = borrow_q;
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8 and WIDTH=1 instances).
module tb_serial_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       start8, bin8, busy8, done8, borrow8;
    logic [7:0] a8, b8, diff8;

    logic       start1, bin1, busy1, done1, borrow1;
    logic [0:0] a1, b1, diff1;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .START(start8), .A(a8), .B(b8), .BIN(bin8),
        .BUSY(busy8), .DONE(done8), .DIFF(diff8), .BORROW(borrow8)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .START(start1), .A(a1), .B(b1), .BIN(bin1),
        .BUSY(busy1), .DONE(done1), .DIFF(diff1), .BORROW(borrow1)
    );

    typedef struct {
        logic [7:0]  diff;
        logic        borrow;
        int unsigned cyc;
    } exp_t;

    exp_t q8[$];
    exp_t q1[$];

    int vectors     = 0;
    int miscompares = 0;

    int unsigned cyc = 0;
    logic        rst_seen = 1'b1;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    logic [7:0] held8   = '0;
    logic       held_b8 = 1'b0;
    logic       held1   = 1'b0;
    logic       held_b1 = 1'b0;

    // Reference: unsigned difference with borrow, reduced modulo 2^w.
    function automatic exp_t model(input int a, input int b, input int bin,
                                   input int w, input int unsigned done_cyc);
        exp_t e;
        int   d;
        int   m;
        m        = 1 << w;
        d        = a - b - bin;
        e.borrow = (d < 0);
        e.diff   = 8'((d + 2 * m) % m);
        e.cyc    = done_cyc;
        return e;
    endfunction

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst_seen === 1'b1) begin
            held8   = '0;
            held_b8 = 1'b0;
        end
        if (done8 === 1'b1) begin
            if (q8.size() == 0) begin
                miscompares++;
                $display("FAIL spurious_done8 at cycle %0d: DIFF=%0d BORROW=%0b, no result expected",
                         cyc, diff8, borrow8);
            end else begin
                e = q8.pop_front();
                vectors++;
                if (diff8 !== e.diff || borrow8 !== e.borrow || cyc != e.cyc) begin
                    miscompares++;
                    $display("FAIL result8: got DIFF=%0d BORROW=%0b cycle=%0d, want DIFF=%0d BORROW=%0b cycle=%0d",
                             diff8, borrow8, cyc, e.diff, e.borrow, e.cyc);
                end
                held8   = e.diff;
                held_b8 = e.borrow;
            end
        end else if (diff8 !== held8 || borrow8 !== held_b8) begin
            miscompares++;
            $display("FAIL hold8 at cycle %0d: got DIFF=%0d BORROW=%0b, want DIFF=%0d BORROW=%0b",
                     cyc, diff8, borrow8, held8, held_b8);
        end
    end

    // Monitor for the 1-bit instance.
    always @(negedge clk) begin
        exp_t       e;
        logic [7:0] ed;
        if (rst_seen === 1'b1) begin
            held1   = 1'b0;
            held_b1 = 1'b0;
        end
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                miscompares++;
                $display("FAIL spurious_done1 at cycle %0d: DIFF=%0b BORROW=%0b", cyc, diff1, borrow1);
            end else begin
                e  = q1.pop_front();
                ed = e.diff;
                vectors++;
                if (diff1[0] !== ed[0] || borrow1 !== e.borrow || cyc != e.cyc) begin
                    miscompares++;
                    $display("FAIL result1: got DIFF=%0b BORROW=%0b cycle=%0d, want DIFF=%0b BORROW=%0b cycle=%0d",
                             diff1, borrow1, cyc, ed[0], e.borrow, e.cyc);
                end
                held1   = ed[0];
                held_b1 = e.borrow;
            end
        end else if (diff1[0] !== held1 || borrow1 !== held_b1) begin
            miscompares++;
            $display("FAIL hold1 at cycle %0d: got DIFF=%0b BORROW=%0b, want DIFF=%0b BORROW=%0b",
                     cyc, diff1, borrow1, held1, held_b1);
        end
    end

    // Presents one request on the 8-bit DUT; operands are scrambled after capture.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic bin, input bit expect_done);
        @(negedge clk);
        a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
        if (expect_done)
            q8.push_back(model(int'(a), int'(b), int'(bin), 8, cyc + 1 + 8));
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    endtask

    task automatic issue1(input logic a, input logic b, input logic bin);
        @(negedge clk);
        a1 = a; b1 = b; bin1 = bin; start1 = 1'b1;
        q1.push_back(model(int'(a), int'(b), int'(bin), 1, cyc + 1 + 1));
        @(negedge clk);
        start1 = 1'b0;
        a1 = 1'($urandom); b1 = 1'($urandom); bin1 = 1'($urandom);
    endtask

    // Waits (bounded) until the 8-bit DUT is back in IDLE.
    task automatic wait_idle8();
        for (int i = 0; i < 40; i++) begin
            if (busy8 === 1'b0 && done8 === 1'b0) return;
            @(negedge clk);
        end
        miscompares++;
        $display("FAIL idle_timeout8: BUSY=%0b DONE=%0b, want both 0 within 40 cycles", busy8, done8);
    endtask

    task automatic wait_idle1();
        for (int i = 0; i < 20; i++) begin
            if (busy1 === 1'b0 && done1 === 1'b0) return;
            @(negedge clk);
        end
        miscompares++;
        $display("FAIL idle_timeout1: BUSY=%0b DONE=%0b, want both 0 within 20 cycles", busy1, done1);
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin);
        issue8(a, b, bin, 1'b1);
        wait_idle8();
    endtask

    initial begin
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state of both instances.
        vectors++;
        if ({busy8, done8, diff8, borrow8} !== 11'd0 || {busy1, done1, diff1, borrow1} !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_state: got w8 BUSY=%0b DONE=%0b DIFF=%0d BORROW=%0b w1 BUSY=%0b DONE=%0b DIFF=%0b BORROW=%0b, want all 0",
                     busy8, done8, diff8, borrow8, busy1, done1, diff1, borrow1);
        end

        // Directed cases.
        run8(8'd100, 8'd37, 1'b0);
        run8(8'd5,   8'd10, 1'b0);
        run8(8'd0,   8'd0,  1'b1);
        run8(8'd255, 8'd255, 1'b0);
        run8(8'd0,   8'd255, 1'b1);

        // START during a busy run is ignored.
        issue8(8'd9, 8'd4, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        a8 = 8'd200; b8 = 8'd1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_idle8();
        repeat (12) @(negedge clk);

        // Reset in cycle 4 of a run abandons it.
        issue8(8'd50, 8'd20, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || diff8 !== 8'd0 || borrow8 !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: got BUSY=%0b DONE=%0b DIFF=%0d BORROW=%0b, want all 0",
                     busy8, done8, diff8, borrow8);
        end
        rst = 1'b0;
        repeat (12) @(negedge clk);
        run8(8'd77, 8'd33, 1'b1);

        // Randomized back-to-back and spaced requests.
        for (int n = 0; n < 40; n++) begin
            issue8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
            wait_idle8();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Full truth table of the 1-bit instance.
        for (int k = 0; k < 8; k++) begin
            logic [2:0] abc;
            abc = 3'(k);
            issue1(abc[2], abc[1], abc[0]);
            wait_idle1();
        end

        repeat (4) @(negedge clk);
        if (q8.size() != 0 || q1.size() != 0) begin
            miscompares++;
            $display("FAIL missing_done: %0d (w8) and %0d (w1) results never delivered, want 0",
                     q8.size(), q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
